// File: rtl/byte_ram_responder_pkg.sv
// Shared constants and helpers for the byte-serial RAM responder.
// The I/O window and offsets match the CPU memory controller's map.
package byte_ram_responder_pkg;

  localparam int ByteLen = 8;
  localparam int AddrLen = 32;

  localparam logic [AddrLen-1:0] IO_BASE     = 32'h30000;
  localparam logic [2:0]         IO_TX_OFF   = 3'h0;
  localparam logic [2:0]         IO_STAT_OFF = 3'h4;
  localparam logic [2:0]         IO_HALT_OFF = 3'h4;

  typedef enum logic [2:0] {
    ACC_NONE,
    ACC_RAM_RD,
    ACC_RAM_WR,
    ACC_IO_RD,
    ACC_IO_WR
  } acc_kind_e;

  // The I/O window is selected by bits [17:16] alone; everything else aliases RAM.
  function automatic logic is_io(input logic [AddrLen-1:0] a);
    return a[17:16] == IO_BASE[17:16];
  endfunction

  function automatic acc_kind_e classify(input logic acc, input logic wr, input logic io);
    if (!acc) return ACC_NONE;
    if (wr)   return io ? ACC_IO_WR : ACC_RAM_WR;
    return io ? ACC_IO_RD : ACC_RAM_RD;
  endfunction

endpackage

// File: rtl/byte_ram_responder_if.sv
// Byte-serial RAM port between the CPU memory controller and the responder,
// bundled with the TX byte stream and halt flag.
interface byte_ram_responder_if;
  import byte_ram_responder_pkg::*;

  logic [AddrLen-1:0] a_i;
  logic               wr_i;
  logic [ByteLen-1:0] d_i;
  logic [ByteLen-1:0] d_o;
  logic               rdy_o;
  logic [ByteLen-1:0] tx_data_o;
  logic               tx_valid_o;
  logic               tx_ready_i;
  logic               halt_o;

  modport master (
    output a_i, wr_i, d_i, tx_ready_i,
    input  d_o, rdy_o, tx_data_o, tx_valid_o, halt_o
  );

  modport slave (
    input  a_i, wr_i, d_i, tx_ready_i,
    output d_o, rdy_o, tx_data_o, tx_valid_o, halt_o
  );

endinterface

// File: rtl/byte_ram_responder_byte_fifo.sv
// Synchronous byte FIFO with power-of-two depth; head reads as zero when empty
// so the TX data output is clean straight out of reset.
module byte_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] buf_q [DEPTH];
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & !full_o;
  assign do_pop  = pop_i & !empty_o;
  assign head_o  = empty_o ? '0 : buf_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) buf_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/byte_ram_responder.sv
// Responder for the CPU byte-serial RAM port: RAM behind a registered read,
// plus an I/O window with a TX FIFO, status and sticky halt register.
module byte_ram_responder
  import byte_ram_responder_pkg::*;
#(
  parameter int ADDR_W     = 17,
  parameter int FIFO_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  byte_ram_responder_if.slave bus
);

  logic [ByteLen-1:0] mem_q [2**ADDR_W];
  logic [ByteLen-1:0] d_q, d_d;
  logic               halt_q, halt_d;

  logic [ADDR_W-1:0]  idx;
  logic [2:0]         off;
  logic               io_sel;
  logic               rdy;
  acc_kind_e          kind;
  logic               ram_we;
  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ByteLen-1:0] fifo_head;
  logic               unused_a;

  assign idx      = bus.a_i[ADDR_W-1:0];
  assign off      = bus.a_i[2:0];
  assign io_sel   = is_io(bus.a_i);
  assign unused_a = ^bus.a_i;

  // Ready depends only on registered state so the core's stall has no address path.
  assign rdy = !fifo_full & !halt_q;

  always_comb begin
    kind      = classify(rdy, bus.wr_i, io_sel);
    ram_we    = (kind == ACC_RAM_WR);
    fifo_push = (kind == ACC_IO_WR) && (off == IO_TX_OFF);
    fifo_pop  = !fifo_empty & bus.tx_ready_i;
    halt_d    = halt_q | ((kind == ACC_IO_WR) && (off == IO_HALT_OFF));
  end

  always_comb begin
    d_d = d_q;
    case (kind)
      ACC_RAM_RD: d_d = mem_q[idx];
      ACC_IO_RD:  d_d = (off == IO_STAT_OFF) ?
                        {{(ByteLen-2){1'b0}}, fifo_full, fifo_empty} : '0;
      default:    d_d = d_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      d_q    <= '0;
      halt_q <= 1'b0;
    end else begin
      d_q    <= d_d;
      halt_q <= halt_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) mem_q[idx] <= bus.d_i;
  end

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ByteLen)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .data_i  (bus.d_i),
    .pop_i   (fifo_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  assign bus.d_o        = d_q;
  assign bus.rdy_o      = rdy;
  assign bus.tx_data_o  = fifo_head;
  assign bus.tx_valid_o = !fifo_empty;
  assign bus.halt_o     = halt_q;

endmodule

// File: doc/byte_ram_responder.md
# byte_ram_responder

Responder end of the byte-serial RAM port driven by the CPU memory controller. Each cycle it accepts one byte access (address, read/write, write byte). It returns read data one cycle later, behind a 2^ADDR_W-byte RAM. It also decodes a small I/O window at 0x30000: a TX byte FIFO toward the UART/host, a status register and a halt register. Its `rdy_o` output is the global CPU ready, and it is used to backpressure the whole core when the TX FIFO is full or the program has halted.

## Interface
- `ADDR_W`, 17 — RAM address width; RAM size is 2^ADDR_W bytes.
- `FIFO_DEPTH`, 8 — TX FIFO depth in bytes; must be a power of 2, ≥ 2.
- `clk` input 1 — clock; all state changes on the rising edge.
- `rst` input 1 — reset, synchronous, active-low.
- `a_i` input 32 — byte address from the memory controller.
- `wr_i` input 1 — 1 = write, 0 = read.
- `d_i` input 8 — write byte.
- `d_o` output 8 — read byte, registered.
- `rdy_o` output 1 — CPU ready; the controller and core advance only when this is 1.
- `tx_data_o` output 8 — FIFO head byte.
- `tx_valid_o` output 1 — FIFO non-empty.
- `tx_ready_i` input 1 — sink accepts the head byte this cycle.
- `halt_o` output 1 — sticky; program wrote the halt register.

## Operation
- **Decode:**
  - `io_sel = (a_i[17:16] == 2'b11)`.
  - Otherwise RAM, indexed by `a_i[ADDR_W-1:0]`; upper bits are ignored (aliasing is allowed).
- **Accepted access:** `acc = rdy_o`. When `rdy_o = 0`, nothing is written, no FIFO push occurs and `d_o` holds. The controller holds its request stable, and the access retries on the first cycle `rdy_o = 1`.
- **RAM write:** if `acc & wr_i & !io_sel`, then `mem[idx] <= d_i`.
- **RAM read:** if `acc & !wr_i & !io_sel`, then `d_o <= mem[idx]`.
- **I/O writes** (`acc & wr_i & io_sel`, decode on `a_i[2:0]`):
  - `0x0` pushes `d_i` into the TX FIFO.
  - `0x4` sets `halt_o`.
  - Other offsets are ignored.
- **I/O reads** (`acc & !wr_i & io_sel`):
  - `0x0` returns 0x00 (no RX path).
  - `0x4` returns `{6'b0, fifo_full, fifo_empty}`.
  - Other offsets return 0x00.
- **rdy_o** = `!fifo_full & !halt_o`. It is combinational from registered state only, with no path from `a_i`/`wr_i`.
- **Pop:** on `tx_valid_o & tx_ready_i`.
- **Simultaneous push and pop:**
  - FIFO not full: both occur and the count is unchanged.
  - FIFO full: the push is blocked because `rdy_o = 0`; the pop frees a slot, so `rdy_o` rises the next cycle and the retried push lands then.
- **Halt:** `halt_o` is sticky until reset. The FIFO keeps draining after halt. `rdy_o` stays 0 after halt.
- **Idle parking:** the controller parks on a read of address 0 when idle. These repeated reads are side-effect-free.
- **Reset** (`rst = 0` at an edge):
  - FIFO emptied: pointers = 0, count = 0.
  - `d_o = 0x00`, `tx_valid_o = 0`, `tx_data_o = 0x00`, `halt_o = 0`, so `rdy_o = 1` the cycle after reset.
  - RAM contents are not cleared.
  - Reset asserted mid-burst discards any queued TX bytes.

## Timing
- **Read latency:** exactly 1 cycle. An address presented in cycle N (with `rdy_o = 1`) produces `d_o` valid in cycle N+1, which is when the controller samples it.
- **Write latency:** the write takes effect at the end of the accepting cycle. A read of the same address in the next cycle returns the new byte.
- **Read-during-write:** not possible on a single port; one access per cycle.
- **FIFO latency:**
  - A push at edge N gives `tx_valid_o = 1` from N+1.
  - `tx_data_o` is the head byte, stable while `tx_valid_o & !tx_ready_i`.
- **Full transition:** `fifo_full` is set the edge the count reaches `FIFO_DEPTH`, so `rdy_o` falls in the same cycle the full state becomes visible. The count width is `$clog2(FIFO_DEPTH) + 1`, and pointers wrap modulo `FIFO_DEPTH`.

## Structure
- **Shared package:** `IO_BASE = 32'h30000`, `IO_TX_OFF = 3'h0`, `IO_STAT_OFF = 3'h4`, `IO_HALT_OFF = 3'h4`, plus the `ByteLen`/`AddrLen` constants already used by the memory controller.
- **Sub-module `byte_fifo`:** synchronous FIFO (`DEPTH` parameter) with push/pop/full/empty/head. The top-level module holds the RAM array, decode, read register and halt flag.

## Test plan
- Write 0xA5 to address 0x00010, then read 0x00010 the next cycle → `d_o = 0xA5` exactly one cycle after the read address is presented.
- Four consecutive writes to 0x30000 (0x48, 0x69, 0x21, 0x0A) with `tx_ready_i = 1` → `tx_data_o` emits 0x48, 0x69, 0x21, 0x0A in order, each byte once, `rdy_o` stays 1.
- With `tx_ready_i = 0`, write 9 bytes to 0x30000 (DEPTH = 8) → `rdy_o` drops after the 8th; the 9th is held. Raising `tx_ready_i` for one cycle pops 1 byte, `rdy_o` returns, the 9th byte is pushed exactly once, and the count is 8.
- Read 0x30004 when empty → 0x01; after one push → 0x00; when full → not reachable, because `rdy_o = 0`.
- Write to 0x30004 → `halt_o = 1` and `rdy_o = 0` from the next cycle; queued TX bytes still drain. Asserting `rst = 0` → `halt_o = 0`, `rdy_o = 1`, FIFO empty, `d_o = 0x00`.
- Reset asserted with 5 bytes queued, followed by a read of a previously written RAM address → FIFO empty after reset, and the RAM byte is preserved.
